// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add multiply
// and restoring shift-subtract divide, sequenced by an IDLE/CALC/DONE FSM.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       ALUctr,
   input  logic [WIDTH-1:0] busA,
   input  logic [WIDTH-1:0] busB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] ALUresult,
   output logic [WIDTH-1:0] ALUresultHi,
   output logic             Zero,
   output logic             Overflow
);
   // state | meaning
   // IDLE  | waiting for start
   // CALC  | one multiply/divide iteration per cycle
   // DONE  | results valid, done pulses for this cycle
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_ADDU  = 4'b0001;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_SUBU  = 4'b0011;
   localparam logic [3:0] OP_OR    = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_XOR   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_SLTU  = 4'b1000;
   localparam logic [3:0] OP_MULTU = 4'b1001;
   localparam logic [3:0] OP_DIVU  = 4'b1010;

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             op_mul;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] wk_hi, wk_lo;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic [WIDTH-1:0] add_res, sub_res, sc_res;
   logic             sc_ovf;
   logic [WIDTH:0]   mul_sum, div_sh;
   logic [WIDTH-1:0] div_rem;
   logic             div_ge;
   logic             accept, iter_op, last_iter;

   assign accept    = start && (state == IDLE);
   assign iter_op   = (ALUctr == OP_MULTU) || (ALUctr == OP_DIVU);
   assign last_iter = (state == CALC) && (cnt == LAST);
   assign add_res   = busA + busB;
   assign sub_res   = busA - busB;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = iter_op ? CALC : DONE;
         CALC:    if (cnt == LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   always_comb begin
      sc_res = '0;
      sc_ovf = 1'b0;
      case (ALUctr)
         OP_ADD: begin
            sc_res = add_res;
            sc_ovf = (busA[WIDTH-1] == busB[WIDTH-1]) && (add_res[WIDTH-1] != busA[WIDTH-1]);
         end
         OP_ADDU: sc_res = add_res;
         OP_SUB: begin
            sc_res = sub_res;
            sc_ovf = (busA[WIDTH-1] != busB[WIDTH-1]) && (sub_res[WIDTH-1] != busA[WIDTH-1]);
         end
         OP_SUBU: sc_res = sub_res;
         OP_OR:   sc_res = busA | busB;
         OP_AND:  sc_res = busA & busB;
         OP_XOR:  sc_res = busA ^ busB;
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(busA) < $signed(busB))};
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (busA < busB)};
         default: sc_res = '0;
      endcase
   end

   // wk_hi: product high half / partial remainder; wk_lo: multiplier / quotient
   always_comb begin
      mul_sum = {1'b0, wk_hi} + ({1'b0, opnd} & {(WIDTH+1){wk_lo[0]}});
      div_sh  = {wk_hi, wk_lo[WIDTH-1]};
      div_ge  = div_sh >= {1'b0, opnd};
      div_rem = div_sh[WIDTH-1:0] - opnd;
      if (op_mul) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], wk_lo[WIDTH-1:1]};
      end else begin
         step_hi = div_ge ? div_rem : div_sh[WIDTH-1:0];
         step_lo = {wk_lo[WIDTH-2:0], div_ge};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         op_mul      <= 1'b0;
         opnd        <= '0;
         wk_hi       <= '0;
         wk_lo       <= '0;
         ALUresult   <= '0;
         ALUresultHi <= '0;
         Zero        <= 1'b0;
         Overflow    <= 1'b0;
      end else if (accept) begin
         cnt    <= '0;
         op_mul <= (ALUctr == OP_MULTU);
         opnd   <= (ALUctr == OP_MULTU) ? busA : busB;
         wk_hi  <= '0;
         wk_lo  <= (ALUctr == OP_MULTU) ? busB : busA;
         if (!iter_op) begin
            ALUresult   <= sc_res;
            ALUresultHi <= '0;
            Zero        <= (sc_res == '0);
            Overflow    <= sc_ovf;
         end
      end else if (state == CALC) begin
         cnt   <= cnt + 1'b1;
         wk_hi <= step_hi;
         wk_lo <= step_lo;
         if (last_iter) begin
            ALUresult   <= step_lo;
            ALUresultHi <= step_hi;
            Zero        <= (step_lo == '0);
            Overflow    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=32: single-cycle ops, multu/divu latency
// and results, busy-time start rejection, mid-operation reset and back-to-back ops.
module tb_alu_mc;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  ALUctr = 4'b0000;
   logic [31:0] busA = '0, busB = '0;
   logic        busy, done, Zero, Overflow;
   logic [31:0] ALUresult, ALUresultHi;
   int          total = 0;
   int          bad = 0;

   alu_mc #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .ALUctr(ALUctr), .busA(busA), .busB(busB),
      .busy(busy), .done(done), .ALUresult(ALUresult), .ALUresultHi(ALUresultHi),
      .Zero(Zero), .Overflow(Overflow)
   );

   always #5 clk = ~clk;

   // Issue one op; lat = negedges from acceptance until done (-1 on timeout)
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
      @(negedge clk);
      ALUctr = op; busA = a; busB = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (done) begin lat = i; break; end
      end
   endtask

   task automatic test_reset;
      #2;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if ({ALUresult, ALUresultHi} !== 64'h0) begin bad++; $display("FAIL reset_res got=%h_%h exp=0", ALUresultHi, ALUresult); end
      total++; if ({Zero, Overflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {Zero, Overflow}); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add;
      int lat;
      run_op(4'b0000, 32'h7FFF_FFFF, 32'h1, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL add_lat got=%0d exp=1", lat); end
      total++; if (ALUresult !== 32'h8000_0000) begin bad++; $display("FAIL add_res got=%h exp=80000000", ALUresult); end
      total++; if ({Overflow, Zero} !== 2'b10) begin bad++; $display("FAIL add_flags got=%b exp=10", {Overflow, Zero}); end
      run_op(4'b0001, 32'h7FFF_FFFF, 32'h1, lat);
      total++; if ({ALUresult, Overflow} !== {32'h8000_0000, 1'b0}) begin bad++; $display("FAIL addu got=%h ovf=%b exp=80000000 ovf=0", ALUresult, Overflow); end
      run_op(4'b0010, 32'h8000_0000, 32'h1, lat);
      total++; if ({ALUresult, Overflow} !== {32'h7FFF_FFFF, 1'b1}) begin bad++; $display("FAIL sub_ovf got=%h ovf=%b exp=7fffffff ovf=1", ALUresult, Overflow); end
      run_op(4'b0011, 32'h8000_0000, 32'h1, lat);
      total++; if ({ALUresult, Overflow} !== {32'h7FFF_FFFF, 1'b0}) begin bad++; $display("FAIL subu got=%h ovf=%b exp=7fffffff ovf=0", ALUresult, Overflow); end
   endtask

   task automatic test_sub_slt;
      int lat;
      run_op(4'b0010, 32'd5, 32'd5, lat);
      total++; if ({ALUresult, Zero, Overflow} !== {32'h0, 1'b1, 1'b0}) begin bad++; $display("FAIL sub_zero got=%h z=%b o=%b exp=0 z=1 o=0", ALUresult, Zero, Overflow); end
      run_op(4'b0111, 32'hFFFF_FFFF, 32'h1, lat);
      total++; if ({ALUresult, Zero} !== {32'h1, 1'b0}) begin bad++; $display("FAIL slt got=%h z=%b exp=1 z=0", ALUresult, Zero); end
      run_op(4'b1000, 32'hFFFF_FFFF, 32'h1, lat);
      total++; if ({ALUresult, Zero} !== {32'h0, 1'b1}) begin bad++; $display("FAIL sltu got=%h z=%b exp=0 z=1", ALUresult, Zero); end
      run_op(4'b0110, 32'hFF00_F0F0, 32'h0F0F_F0F0, lat);
      total++; if (ALUresult !== 32'hF00F_0000) begin bad++; $display("FAIL xor got=%h exp=f00f0000", ALUresult); end
   endtask

   task automatic test_multu;
      int lat;
      @(negedge clk);
      ALUctr = 4'b1001; busA = 32'hFFFF_FFFF; busB = 32'hFFFF_FFFF; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; busA = 32'h0; busB = 32'h0;
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (i == 3) begin
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL multu_busy got=%b exp=1", busy); end
         end
         if (i >= 5 && i <= 8) begin start = 1'b1; ALUctr = 4'b0000; busA = 32'd1; busB = 32'd1; end
         else start = 1'b0;
         if (done) begin lat = i; break; end
      end
      total++; if (lat !== 33) begin bad++; $display("FAIL multu_lat got=%0d exp=33", lat); end
      total++; if ({ALUresultHi, ALUresult} !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL multu_res got=%h_%h exp=fffffffe_00000001", ALUresultHi, ALUresult); end
      total++; if ({Zero, Overflow} !== 2'b00) begin bad++; $display("FAIL multu_flags got=%b exp=00", {Zero, Overflow}); end
      @(negedge clk);
      total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL multu_after got done=%b busy=%b exp=00", done, busy); end
      total++; if (ALUresultHi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hold got=%h exp=fffffffe", ALUresultHi); end
      run_op(4'b1001, 32'd12345, 32'd678, lat);
      total++; if ({ALUresultHi, ALUresult} !== 64'd8369910) begin bad++; $display("FAIL multu_small got=%h_%h exp=0_7fb6f6", ALUresultHi, ALUresult); end
   endtask

   task automatic test_divu;
      int lat;
      run_op(4'b1010, 32'd100, 32'd7, lat);
      total++; if (lat !== 33) begin bad++; $display("FAIL divu_lat got=%0d exp=33", lat); end
      total++; if ({ALUresult, ALUresultHi} !== {32'd14, 32'd2}) begin bad++; $display("FAIL divu got q=%0d r=%0d exp q=14 r=2", ALUresult, ALUresultHi); end
      run_op(4'b1010, 32'd3, 32'd7, lat);
      total++; if ({ALUresult, ALUresultHi, Zero} !== {32'd0, 32'd3, 1'b1}) begin bad++; $display("FAIL divu_zeroq got q=%0d r=%0d z=%b exp q=0 r=3 z=1", ALUresult, ALUresultHi, Zero); end
      run_op(4'b1010, 32'd9, 32'd0, lat);
      total++; if (lat !== 33) begin bad++; $display("FAIL div0_lat got=%0d exp=33", lat); end
      total++; if ({ALUresult, ALUresultHi, Overflow} !== {32'hFFFF_FFFF, 32'd9, 1'b0}) begin bad++; $display("FAIL div0 got q=%h r=%0d o=%b exp q=ffffffff r=9 o=0", ALUresult, ALUresultHi, Overflow); end
   endtask

   task automatic test_reserved;
      int lat;
      run_op(4'b1100, 32'h1234, 32'h5678, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL rsv_lat got=%0d exp=1", lat); end
      total++; if ({ALUresult, ALUresultHi, Zero, Overflow} !== {64'h0, 2'b10}) begin bad++; $display("FAIL rsv got=%h_%h z=%b o=%b exp=0_0 z=1 o=0", ALUresultHi, ALUresult, Zero, Overflow); end
      run_op(4'b1010, 32'd50, 32'd9, lat);
      run_op(4'b0100, 32'h0F, 32'hF0, lat);
      total++; if ({ALUresult, ALUresultHi} !== {32'hFF, 32'h0}) begin bad++; $display("FAIL or_hi got=%h hi=%h exp=ff hi=0", ALUresult, ALUresultHi); end
   endtask

   task automatic test_reset_mid;
      int lat;
      @(negedge clk);
      ALUctr = 4'b1001; busA = 32'h1234; busB = 32'h10; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= 10; i++) @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rstmid_ctl got busy=%b done=%b exp=00", busy, done); end
      total++; if ({ALUresult, ALUresultHi, Zero, Overflow} !== 66'h0) begin bad++; $display("FAIL rstmid_out got=%h_%h z=%b exp=0", ALUresultHi, ALUresult, Zero); end
      @(negedge clk);
      rst = 1'b0; ALUctr = 4'b0000; busA = 32'd2; busB = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done) begin lat = i; break; end
      end
      total++; if (lat !== 1) begin bad++; $display("FAIL rstmid_lat got=%0d exp=1", lat); end
      total++; if (ALUresult !== 32'd5) begin bad++; $display("FAIL rstmid_add got=%0d exp=5", ALUresult); end
      for (int i = 1; i <= 35; i++) begin
         @(negedge clk);
         if (done) begin
            total++; bad++; $display("FAIL rstmid_stray_done got=1 exp=0 at=%0d", i);
            break;
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0]  ops [4] = '{4'b0100, 4'b0101, 4'b0100, 4'b0101};
      logic [31:0] av  [4] = '{32'hF0F0_0000, 32'hFF00_FF00, 32'h1, 32'hA};
      logic [31:0] bv  [4] = '{32'h0000_0F0F, 32'h0F0F_0F0F, 32'h2, 32'h5};
      logic [31:0] ev  [4] = '{32'hF0F0_0F0F, 32'h0F00_0F00, 32'h3, 32'h0};
      @(negedge clk);
      ALUctr = ops[0]; busA = av[0]; busB = bv[0]; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++; if ({done, ALUresult} !== {1'b1, ev[i]}) begin bad++; $display("FAIL b2b_pulse%0d got done=%b res=%h exp done=1 res=%h", i, done, ALUresult, ev[i]); end
         if (i < 3) begin ALUctr = ops[i+1]; busA = av[i+1]; busB = bv[i+1]; end
         else start = 1'b0;
         @(negedge clk);
         total++; if ({done, ALUresult} !== {1'b0, ev[i]}) begin bad++; $display("FAIL b2b_hold%0d got done=%b res=%h exp done=0 res=%h", i, done, ALUresult, ev[i]); end
      end
      total++; if (Zero !== 1'b1) begin bad++; $display("FAIL b2b_zero got=%b exp=1", Zero); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_slt();
      test_multu();
      test_divu();
      test_reserved();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
